// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one shared resource to N level-sensitive requesters,
// with a bounded hold time per ownership and a one-cycle gap between owners.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic          state_dbg
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_idx = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) win_idx = idx;
    end
  end

  // grant_id doubles as the owner index; it holds its value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= GRANT;
            grant       <= N'(1) << win_idx;
            grant_valid <= 1'b1;
            grant_id    <= win_idx;
            hold_cnt    <= HW'(1);
            ptr         <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          end
        end
        GRANT: begin
          if (!req[grant_id] || hold_cnt == MAX_HOLD_C) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized and directed bench for rr_arbiter: a queue-based rotating-priority
// model predicts each cycle's outputs, a monitor compares them after every edge.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IW       = $clog2(N);
  localparam int W        = 1 + N + 1 + IW;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          state_dbg;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [W-1:0] exp_q[$];

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Priority is a list of requester indices in current preference order; a winner
  // is rotated to the back so the one after it becomes most preferred.
  int order[$];
  int m_owner;
  int m_budget;
  int m_id;

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    m_owner = -1;
    m_id    = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    logic [N-1:0] g;
    int pos;
    cycle++;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      pos = -1;
      for (int p = 0; p < N; p++)
        if (pos < 0 && req[order[p]]) pos = p;
      if (pos >= 0) begin
        m_owner  = order[pos];
        m_id     = m_owner;
        m_budget = MAX_HOLD - 1;
        for (int r = 0; r <= pos; r++) order.push_back(order.pop_front());
      end
    end else begin
      if (!req[m_owner] || m_budget == 0) m_owner = -1;
      else m_budget--;
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_q.push_back({(m_owner >= 0), g, (m_owner >= 0), IW'(m_id)});
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow cycle=%0d actual=empty expected=entry", cycle);
    end else begin
      e = exp_q.pop_front();
      check("state",       int'(state_dbg),   int'(e[W-1]));
      check("grant",       int'(grant),       int'(e[W-2 -: N]));
      check("grant_valid", int'(grant_valid), int'(e[IW]));
      check("grant_id",    int'(grant_id),    int'(e[IW-1:0]));
      check("onehot",      int'($countones(grant) <= 1), 1);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] r, input logic rs, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req = r;
      rst = rs;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    req = 4'b1111;
    // Reset with all requesting, then release: first grant to requester 0.
    drive(4'b1111, 1'b1, 2);
    // Full rotation with everyone requesting.
    drive(4'b1111, 1'b0, 40);
    drive(4'b0000, 1'b0, 3);
    // Single requester held for three cycles.
    drive(4'b0100, 1'b0, 3);
    drive(4'b0000, 1'b0, 3);
    // Requester 1 alone, then 0 and 1 together: wrap past 2 and 3 to 0.
    drive(4'b0010, 1'b0, 2);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0011, 1'b0, 12);
    drive(4'b0000, 1'b0, 2);
    // Sole requester hitting hold expiry repeatedly.
    drive(4'b0001, 1'b0, 30);
    drive(4'b0000, 1'b0, 2);
    // Reset during the 4th cycle of owner 2's grant, then all request.
    drive(4'b0100, 1'b0, 4);
    drive(4'b1111, 1'b1, 1);
    drive(4'b1111, 1'b0, 6);
    drive(4'b0000, 1'b0, 2);
    // Randomized traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      drive(r, ($urandom_range(0, 149) == 0), 1);
    end
    drive(4'b0000, 1'b0, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
